cpu_controller: RTL and testbench



---
 rtl/cpu_controller.sv | 157 +++++++++++++++
 tb/tb_cpu_controller.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// Simple RISC Machine controller: instruction register, decoder and Moore FSM driving the datapath.
// One micro-step per clock; load/s are honoured only while idle in WAIT (w=1), ignored otherwise.
module cpu_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [1:0]  vsel,
    output logic [2:0]  writenum,
    output logic [2:0]  readnum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_MOVIMM = 3'd2,
        S_GETA   = 3'd3,
        S_GETB   = 3'd4,
        S_ALU    = 3'd5,
        S_WRITE  = 3'd6
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] ir;

    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [2:0]  rm;
    logic        is_movimm;
    logic        is_movreg;
    logic        is_mvn;
    logic        is_cmp;
    logic        is_alu3;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign rm     = ir[2:0];

    assign is_movimm = (opcode == 3'b110) && (op == 2'b10);
    assign is_movreg = (opcode == 3'b110) && (op == 2'b00);
    assign is_mvn    = (opcode == 3'b101) && (op == 2'b11);
    assign is_cmp    = (opcode == 3'b101) && (op == 2'b01);
    assign is_alu3   = (opcode == 3'b101) && (op != 2'b11);

    assign shift  = ir[4:3];
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};

    // IR only changes while idle, so a running instruction always sees a stable word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= 16'h0000;
        end else if (state == S_WAIT && load) begin
            ir <= in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        w         = 1'b0;
        vsel      = 2'b00;
        writenum  = 3'b000;
        readnum   = 3'b000;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        ALUop     = 2'b00;

        case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_movimm) begin
                    state_nxt = S_MOVIMM;
                end else if (is_movreg || is_mvn) begin
                    state_nxt = S_GETB;
                end else if (is_alu3) begin
                    state_nxt = S_GETA;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_MOVIMM: begin
                writenum  = rn;
                vsel      = 2'b10;
                write     = 1'b1;
                state_nxt = S_WAIT;
            end
            S_GETA: begin
                readnum   = rn;
                loada     = 1'b1;
                state_nxt = S_GETB;
            end
            S_GETB: begin
                readnum   = rm;
                loadb     = 1'b1;
                state_nxt = S_ALU;
            end
            S_ALU: begin
                // MOV-reg reuses the adder with A forced to zero.
                ALUop = is_movreg ? 2'b00 : op;
                asel  = is_movreg || is_mvn;
                if (is_cmp) begin
                    loads     = 1'b1;
                    state_nxt = S_WAIT;
                end else begin
                    loadc     = 1'b1;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                writenum  = rd;
                vsel      = 2'b00;
                write     = 1'b1;
                state_nxt = S_WAIT;
            end
            default: begin
                state_nxt = S_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized bench: a behavioural datapath driven by the DUT strobes is compared against an ISA-level model.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic        w;
    logic [1:0]  vsel;
    logic [2:0]  writenum;
    logic [2:0]  readnum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;
    logic [15:0] sximm5;

    always #5 clk = ~clk;

    cpu_controller dut (
        .clk(clk), .rst_n(rst_n), .in(in), .load(load), .s(s), .w(w),
        .vsel(vsel), .writenum(writenum), .readnum(readnum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
        .sximm8(sximm8), .sximm5(sximm5)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] sh);
        case (sh)
            2'b00:   return v;
            2'b01:   return {v[14:0], 1'b0};
            2'b10:   return {1'b0, v[15:1]};
            default: return {v[15], v[15:1]};
        endcase
    endfunction

    function automatic logic [15:0] sx8(input logic [15:0] word);
        return {{8{word[7]}}, word[7:0]};
    endfunction

    function automatic logic [15:0] sx5(input logic [15:0] word);
        return {{11{word[4]}}, word[4:0]};
    endfunction

    // Behavioural datapath: strobes captured mid-cycle, applied on the following rising edge.
    logic [15:0] dp_r [8] = '{default: 16'h0000};
    logic [15:0] dp_a = 16'h0, dp_b = 16'h0, dp_c = 16'h0;
    logic        dp_z = 1'b0, dp_n = 1'b0;
    logic        c_write = 0, c_loada = 0, c_loadb = 0, c_loadc = 0, c_loads = 0, c_asel = 0, c_bsel = 0;
    logic [1:0]  c_vsel = 0, c_shift = 0, c_aluop = 0;
    logic [2:0]  c_wn = 0, c_rn = 0;
    logic [15:0] c_imm8 = 0, c_imm5 = 0;

    always @(negedge clk) begin
        c_write <= write;  c_loada <= loada;  c_loadb <= loadb;
        c_loadc <= loadc;  c_loads <= loads;  c_asel <= asel;  c_bsel <= bsel;
        c_vsel <= vsel;    c_shift <= shift;  c_aluop <= ALUop;
        c_wn <= writenum;  c_rn <= readnum;   c_imm8 <= sximm8; c_imm5 <= sximm5;
    end

    always @(posedge clk) begin : dp_model
        logic [15:0] ain, bin, res;
        ain = c_asel ? 16'h0 : dp_a;
        bin = c_bsel ? c_imm5 : shf(dp_b, c_shift);
        case (c_aluop)
            2'b00:   res = ain + bin;
            2'b01:   res = ain - bin;
            2'b10:   res = ain & bin;
            default: res = ~bin;
        endcase
        if (rst_n) begin
            if (c_write) dp_r[c_wn] <= (c_vsel == 2'b10) ? c_imm8 : ((c_vsel == 2'b00) ? dp_c : 16'h0);
            if (c_loada) dp_a <= dp_r[c_rn];
            if (c_loadb) dp_b <= dp_r[c_rn];
            if (c_loadc) dp_c <= res;
            if (c_loads) begin
                dp_z <= (res == 16'h0);
                dp_n <= res[15];
            end
        end
    end

    // ISA-level expectation
    logic [15:0] exp_r [8] = '{default: 16'h0000};
    logic        exp_z = 1'b0, exp_n = 1'b0;

    localparam int K_UNDEF = 0, K_MOVI = 1, K_MOVR = 2, K_ADD = 3, K_CMP = 4, K_AND = 5, K_MVN = 6;

    function automatic int classify(input logic [15:0] word);
        case (word[15:11])
            5'b11010: return K_MOVI;
            5'b11000: return K_MOVR;
            5'b10100: return K_ADD;
            5'b10101: return K_CMP;
            5'b10110: return K_AND;
            5'b10111: return K_MVN;
            default:  return K_UNDEF;
        endcase
    endfunction

    task automatic wait_idle();
        int t = 0;
        while (!w && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("w_ready", w, 1'b1);
    endtask

    task automatic run_instr(input logic [15:0] word, input bit poke);
        int kind, lat, n, cw, cc, cs;
        logic [2:0]  rn, rd, rm;
        logic [15:0] m, diff;
        kind = classify(word);
        rn = word[10:8]; rd = word[7:5]; rm = word[2:0];
        m  = shf(exp_r[rm], word[4:3]);
        case (kind)
            K_MOVI:  begin exp_r[rn] = sx8(word);         lat = 2; end
            K_MOVR:  begin exp_r[rd] = m;                 lat = 4; end
            K_ADD:   begin exp_r[rd] = exp_r[rn] + m;     lat = 5; end
            K_AND:   begin exp_r[rd] = exp_r[rn] & m;     lat = 5; end
            K_MVN:   begin exp_r[rd] = ~m;                lat = 4; end
            K_CMP:   begin
                diff  = exp_r[rn] - m;
                exp_z = (diff == 16'h0);
                exp_n = diff[15];
                lat   = 4;
            end
            default: lat = 1;
        endcase

        wait_idle();
        in = word; load = 1'b1; s = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; s = 1'b0; in = 16'($urandom);
        n = 0; cw = 0; cc = 0; cs = 0;
        while (!w && n < 12) begin
            chk("shift", shift, word[4:3]);
            chk("sximm8", sximm8, sx8(word));
            chk("sximm5", sximm5, sx5(word));
            if (loada) chk("readnum_a", readnum, rn);
            if (loadb) chk("readnum_b", readnum, rm);
            if (write) begin
                cw++;
                chk("writenum", writenum, (kind == K_MOVI) ? rn : rd);
                chk("vsel", vsel, (kind == K_MOVI) ? 2'b10 : 2'b00);
            end
            if (loadc) cc++;
            if (loads) cs++;
            if (loadc || loads) begin
                chk("aluop", ALUop, (kind == K_MOVR) ? 2'b00 : word[12:11]);
                chk("asel", asel, (kind == K_MOVR || kind == K_MVN));
                chk("bsel", bsel, 1'b0);
            end
            if (poke && n == 1) begin
                load = 1'b1;
                in   = ~word;
            end else begin
                load = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        load = 1'b0;
        chk("latency", n, lat);
        chk("n_write", cw, (kind == K_UNDEF || kind == K_CMP) ? 0 : 1);
        chk("n_loadc", cc, (kind == K_ADD || kind == K_AND || kind == K_MVN || kind == K_MOVR) ? 1 : 0);
        chk("n_loads", cs, (kind == K_CMP) ? 1 : 0);
        chk("ir_kept", sximm8, sx8(word));
        for (int i = 0; i < 8; i++) chk("reg", dp_r[i], exp_r[i]);
        chk("status_z", dp_z, exp_z);
        chk("status_n", dp_n, exp_n);
    endtask

    function automatic logic [15:0] rand_word(input int kind);
        logic [15:0] wd;
        logic [2:0]  opc;
        wd = 16'($urandom);
        case (kind)
            K_MOVI:  wd[15:11] = 5'b11010;
            K_MOVR:  wd[15:11] = 5'b11000;
            K_ADD:   wd[15:11] = 5'b10100;
            K_CMP:   wd[15:11] = 5'b10101;
            K_AND:   wd[15:11] = 5'b10110;
            K_MVN:   wd[15:11] = 5'b10111;
            default: begin
                opc = 3'($urandom_range(0, 7));
                if (opc == 3'b101) opc = 3'b111;
                if (opc == 3'b110) wd[11] = 1'b1;
                wd[15:13] = opc;
            end
        endcase
        return wd;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; load = 1'b0; s = 1'b0; in = 16'h0;
        #12;
        chk("rst_w", w, 1'b1);
        chk("rst_strobes", {write, loada, loadb, loadc, loads, asel, bsel}, 7'h0);
        chk("rst_sel", {vsel, writenum, readnum, ALUop, shift}, 12'h0);
        chk("rst_imm", {sximm8, sximm5}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_instr(16'hD007, 1'b0);
        chk("r0_7", dp_r[0], 16'h0007);
        run_instr(16'hD102, 1'b0);
        chk("r1_2", dp_r[1], 16'h0002);
        run_instr(16'hA148, 1'b0);
        chk("r2_16", dp_r[2], 16'h0010);
        run_instr(16'hA900, 1'b0);
        chk("cmp_zn", {dp_z, dp_n}, 2'b01);
        run_instr(16'hB860, 1'b1);
        chk("r3_fff8", dp_r[3], 16'hFFF8);
        run_instr(16'hC089, 1'b1);
        chk("r4_4", dp_r[4], 16'h0004);
        run_instr(16'hE000, 1'b0);

        // Abort an ADD in its ALU step; destination must stay untouched.
        wait_idle();
        in = 16'hA5A8; load = 1'b1; s = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; s = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_abort_loadc", loadc, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_w", w, 1'b1);
        chk("abort_strobes", {write, loada, loadb, loadc, loads}, 5'h0);
        chk("abort_ir", sximm8, 16'h0);
        @(posedge clk); @(posedge clk); @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_r5", dp_r[5], exp_r[5]);

        for (int i = 0; i < 8; i++) run_instr({5'b11010, 3'(i), 8'($urandom)}, 1'b0);
        for (int i = 0; i < 60; i++) begin
            run_instr(rand_word($urandom_range(0, 6)), ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
